ldpc_encoder: RTL and testbench

- Systematic LDPC encoder: the transmit-side counterpart of the LDPC decoder (ctrl).
- Accepts a K-bit information word and computes M parity bits serially, one information bit per cycle, against a parameterised generator parity submatrix P.
- Emits the N=K+M codeword in two forms: packed bits, and the decoder's signed WIDTH-per-lane LLR bus.
- Serves as the stimulus source for decoder benches and as the transmit stage in loopback builds.

---
 rtl/ldpc_encoder.sv | 151 +++++++++++++++
 tb/tb_ldpc_encoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_encoder.sv
// Systematic LDPC encoder: serial parity accumulation, codeword as packed bits and BPSK LLR lanes.
// Optional macro LDPC_ENC_LFSR_SRC_EN replaces i_info with an internal 16-bit LFSR source.
module ldpc_encoder #(
    parameter int K = 3,
    parameter int M = 3,
    parameter int WIDTH = 8,
    parameter int AMP = 4,
    parameter logic [K*M-1:0] P_MATRIX = 9'b011_101_110
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     i_val,
    output logic                     i_rdy,
    input  logic [K-1:0]             i_info,
    output logic                     o_val,
    input  logic                     o_rdy,
    output logic [K+M-1:0]           o_code,
    output logic [WIDTH*(K+M)-1:0]   o_data,
    output logic                     o_busy
);

    localparam int N  = K + M;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic signed [WIDTH-1:0] AMP_S = WIDTH'(AMP);

    typedef enum logic [1:0] {IDLE, ENCODE, OUT} state_t;

    state_t               r_state;
    logic [K-1:0]         r_info;
    logic [M-1:0]         r_parity;
    logic [CW-1:0]        r_cnt;
    logic                 r_rdy;
    logic                 r_val;
    logic                 r_busy;
    logic [N-1:0]         r_code;
    logic [WIDTH*N-1:0]   r_data;

    logic [K-1:0]         w_info_src;
    logic [M-1:0]         w_row;
    logic                 w_bit;
    logic [M-1:0]         w_parity_next;
    logic                 w_last;
    logic                 w_accept;

    function automatic logic signed [WIDTH-1:0] llr_map(input logic b);
        return b ? -AMP_S : AMP_S;
    endfunction

    function automatic logic [WIDTH*N-1:0] map_code(input logic [N-1:0] code);
        logic [WIDTH*N-1:0] res;
        res = '0;
        for (int i = 0; i < N; i++) begin
            res[WIDTH*i +: WIDTH] = llr_map(code[i]);
        end
        return res;
    endfunction

    // Select the information bit and P row addressed by the serial counter.
    always_comb begin
        w_row = '0;
        w_bit = 1'b0;
        for (int j = 0; j < K; j++) begin
            if (CW'(j) == r_cnt) begin
                w_row = P_MATRIX[j*M +: M];
                w_bit = r_info[j];
            end
        end
    end

    assign w_parity_next = r_parity ^ (w_bit ? w_row : '0);
    assign w_last        = (r_cnt == CW'(K - 1));
    assign w_accept      = (r_state == IDLE) && i_val;

`ifdef LDPC_ENC_LFSR_SRC_EN
    logic [15:0] r_lfsr;
    logic        w_fb;
    logic        w_unused_info;

    assign w_fb          = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_info_src    = r_lfsr[K-1:0];
    assign w_unused_info = ^i_info;

    always_ff @(posedge clk) begin
        if (xrst) begin
            r_lfsr <= 16'hACE1;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end
`else
    assign w_info_src = i_info;
`endif

    always_ff @(posedge clk) begin
        if (xrst) begin
            r_state  <= IDLE;
            r_info   <= '0;
            r_parity <= '0;
            r_cnt    <= '0;
            r_rdy    <= 1'b1;
            r_val    <= 1'b0;
            r_busy   <= 1'b0;
            r_code   <= '0;
            r_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_val) begin
                        r_info   <= w_info_src;
                        r_parity <= '0;
                        r_cnt    <= '0;
                        r_rdy    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ENCODE;
                    end
                end
                ENCODE: begin
                    r_parity <= w_parity_next;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_code  <= {w_parity_next, r_info};
                        r_data  <= map_code({w_parity_next, r_info});
                        r_val   <= 1'b1;
                        r_state <= OUT;
                    end
                end
                OUT: begin
                    if (o_rdy) begin
                        r_val   <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rdy   <= 1'b1;
                    r_val   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign i_rdy  = r_rdy;
    assign o_val  = r_val;
    assign o_busy = r_busy;
    assign o_code = r_code;
    assign o_data = r_data;

endmodule

// File: tb/tb_ldpc_encoder.sv
// Directed bench for ldpc_encoder (K=3, M=3, WIDTH=8, AMP=4); covers LFSR source when LDPC_ENC_LFSR_SRC_EN is set.
module tb_ldpc_encoder;

    logic        clk = 1'b0;
    logic        xrst;
    logic        i_val;
    logic        i_rdy;
    logic [2:0]  i_info;
    logic        o_val;
    logic        o_rdy;
    logic [5:0]  o_code;
    logic [47:0] o_data;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ldpc_encoder dut (
        .clk    (clk),
        .xrst   (xrst),
        .i_val  (i_val),
        .i_rdy  (i_rdy),
        .i_info (i_info),
        .o_val  (o_val),
        .o_rdy  (o_rdy),
        .o_code (o_code),
        .o_data (o_data),
        .o_busy (o_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame with o_rdy tied high, starting from IDLE.
    task automatic run_frame(input logic [2:0] info, input logic [5:0] exp_code,
                             input logic [47:0] exp_data, input string tag);
        i_val  = 1'b1;
        i_info = info;
        o_rdy  = 1'b1;
        tick();
        i_val = 1'b0;
        check({tag, "_rdy_low"}, i_rdy, 1'b0);
        check({tag, "_busy"}, o_busy, 1'b1);
        tick();
        tick();
        check({tag, "_val_early"}, o_val, 1'b0);
        tick();
        check({tag, "_val"}, o_val, 1'b1);
        check({tag, "_code"}, o_code, exp_code);
        check({tag, "_data"}, o_data, exp_data);
        tick();
        check({tag, "_val_drop"}, o_val, 1'b0);
        check({tag, "_rdy_back"}, i_rdy, 1'b1);
        check({tag, "_busy_drop"}, o_busy, 1'b0);
        check({tag, "_code_kept"}, o_code, exp_code);
    endtask

`ifdef LDPC_ENC_LFSR_SRC_EN
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [5:0] ref_code(input logic [2:0] info);
        logic [2:0] p;
        p = 3'b000;
        if (info[0]) p = p ^ 3'b110;
        if (info[1]) p = p ^ 3'b101;
        if (info[2]) p = p ^ 3'b011;
        return {p, info};
    endfunction

    function automatic logic [47:0] ref_data(input logic [5:0] code);
        logic [47:0] d;
        for (int i = 0; i < 6; i++) d[8*i +: 8] = code[i] ? 8'hFC : 8'h04;
        return d;
    endfunction
`endif

    initial begin
        xrst   = 1'b1;
        i_val  = 1'b0;
        i_info = 3'b000;
        o_rdy  = 1'b0;
        tick();
        tick();
        check("rst_i_rdy", i_rdy, 1'b1);
        check("rst_o_val", o_val, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_code", o_code, 6'b0);
        check("rst_data", o_data, 48'h0);
        xrst = 1'b0;
        tick();

`ifdef LDPC_ENC_LFSR_SRC_EN
        begin
            logic [15:0] s;
            logic [5:0]  c;
            s = 16'hACE1;
            run_frame(3'b000, 6'b110001, 48'hFCFC040404FC, "lfsr_f1");
            s = lfsr_step(s);
            c = ref_code(s[2:0]);
            run_frame(3'b111, c, ref_data(c), "lfsr_f2");
        end
`else
        run_frame(3'b001, 6'b110001, 48'hFCFC040404FC, "info001");
        run_frame(3'b111, 6'b000111, 48'h040404FCFCFC, "info111");
        run_frame(3'b011, 6'b011011, 48'h04FCFC04FCFC, "info011");
        run_frame(3'b000, 6'b000000, 48'h040404040404, "info000");

        // Backpressure: hold OUT for five cycles while a new i_val is offered.
        i_val  = 1'b1;
        i_info = 3'b011;
        o_rdy  = 1'b0;
        tick();
        i_val = 1'b0;
        tick();
        tick();
        tick();
        check("bp_val", o_val, 1'b1);
        for (int k = 0; k < 5; k++) begin
            i_val  = 1'b1;
            i_info = 3'b111;
            tick();
            check("bp_val_hold", o_val, 1'b1);
            check("bp_code_hold", o_code, 6'b011011);
            check("bp_data_hold", o_data, 48'h04FCFC04FCFC);
            check("bp_i_rdy", i_rdy, 1'b0);
        end
        i_val = 1'b0;
        o_rdy = 1'b1;
        tick();
        check("bp_release_val", o_val, 1'b0);
        check("bp_release_rdy", i_rdy, 1'b1);
        check("bp_ignored_code", o_code, 6'b011011);
        tick();
        check("bp_no_frame", o_busy, 1'b0);

        // Reset during the second ENCODE cycle aborts the frame.
        i_val  = 1'b1;
        i_info = 3'b111;
        tick();
        i_val = 1'b0;
        tick();
        xrst = 1'b1;
        tick();
        xrst = 1'b0;
        check("abort_val", o_val, 1'b0);
        check("abort_rdy", i_rdy, 1'b1);
        check("abort_busy", o_busy, 1'b0);
        check("abort_code", o_code, 6'b0);
        check("abort_data", o_data, 48'h0);
        tick();
        tick();
        tick();
        check("abort_no_out", o_val, 1'b0);
        run_frame(3'b001, 6'b110001, 48'hFCFC040404FC, "post_abort");

        // Back-to-back frames with i_val and o_rdy held high.
        begin
            int cyc = 0;
            int c1  = -100;
            int c2  = -1;
            int pulses = 0;
            logic [5:0] code1 = '0;
            logic [5:0] code2 = '0;
            i_val  = 1'b1;
            i_info = 3'b001;
            o_rdy  = 1'b1;
            for (int k = 0; k < 30 && pulses < 2; k++) begin
                tick();
                cyc++;
                if (!i_rdy) i_info = 3'b011;
                if (o_val) begin
                    pulses++;
                    if (pulses == 1) begin
                        c1 = cyc;
                        code1 = o_code;
                    end else begin
                        c2 = cyc;
                        code2 = o_code;
                        i_val = 1'b0;
                    end
                end
            end
            i_val = 1'b0;
            check("b2b_spacing", 64'(c2 - c1), 64'd5);
            check("b2b_code1", code1, 6'b110001);
            check("b2b_code2", code2, 6'b011011);
            tick();
            check("b2b_pulse_end", o_val, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
